// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: occupancy encoding for inter-stage latches and
// per-stage bubble payloads, also used by the hazard unit.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [31:0] IF_ID_BUBBLE  = NOP_INSTR;
  localparam logic [31:0] ID_EX_BUBBLE  = 32'h0000_0000;
  localparam logic [31:0] EX_MEM_BUBBLE = 32'h0000_0000;
  localparam logic [31:0] MEM_WB_BUBBLE = 32'h0000_0000;

  // A latch can take a new entry unless both the main and skid slots are held.
  function automatic logic occ_has_space(input occ_t occ);
    return (occ != OCC_TWO);
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load and clear-to-bubble; reset and clear both return
// the register to BUBBLE_VAL so an empty slot always presents the NOP encoding.
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= BUBBLE_VAL;
    end else if (clear) begin
      q_reg <= BUBBLE_VAL;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble and
// an optional 2-entry skid buffer that keeps in_ready off the out_ready path.
module pipe_stage_latch
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                SKID       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  occ_t              occ_reg;
  occ_t              occ_next;
  logic              main_valid;
  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              main_clear;
  logic              skid_load;
  logic              skid_clear;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  assign main_valid = (occ_reg != OCC_EMPTY);
  assign out_valid  = main_valid;
  assign out_data   = main_q;
  assign occupancy  = occ_reg;

  // With the skid slot, in_ready depends only on state; without it, ready
  // passes straight through from downstream.
  generate
    if (SKID != 0) begin : g_ready_reg
      assign in_ready = rst_n & occ_has_space(occ_reg);
    end else begin : g_ready_comb
      assign in_ready = rst_n & (~main_valid | out_ready);
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_reg <= OCC_EMPTY;
    end else begin
      occ_reg <= occ_next;
    end
  end

  always_comb begin
    occ_next   = occ_reg;
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_d     = in_data;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      // Handshakes still complete this cycle; accepted data is simply dropped.
      occ_next   = OCC_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (occ_reg)
        OCC_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            occ_next  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire && (SKID != 0)) begin
            skid_load = 1'b1;
            occ_next  = OCC_TWO;
          end else if (out_fire) begin
            main_clear = 1'b1;
            occ_next   = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (out_fire) begin
            main_load  = 1'b1;
            main_d     = skid_q;
            skid_clear = 1'b1;
            occ_next   = OCC_ONE;
          end
        end
        default: begin
          occ_next   = OCC_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  pipe_data_reg #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (BUBBLE_VAL)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .q     (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_data_reg #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
      ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_data),
        .q     (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = BUBBLE_VAL;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed and randomized checks of pipe_stage_latch: index 0 is SKID=0,
// index 1 is SKID=1 (both 32-bit), plus a 64-bit SKID=1 instance with bubble 0x13.
module tb_pipe_stage_latch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        flush_s     [2];
  logic        in_valid_s  [2];
  logic        in_ready_s  [2];
  logic [31:0] in_data_s   [2];
  logic        out_valid_s [2];
  logic        out_ready_s [2];
  logic [31:0] out_data_s  [2];
  logic [1:0]  occ_s       [2];

  logic        flush_w, in_valid_w, in_ready_w, out_valid_w, out_ready_w;
  logic [63:0] in_data_w, out_data_w;
  logic [1:0]  occ_w;

  int errors = 0;
  int checks = 0;

  pipe_stage_latch #(.DATA_W(32), .BUBBLE_VAL(32'h0), .SKID(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush_s[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_data(in_data_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_data(out_data_s[0]),
    .occupancy(occ_s[0])
  );

  pipe_stage_latch #(.DATA_W(32), .BUBBLE_VAL(32'h0), .SKID(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush_s[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_data(in_data_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_data(out_data_s[1]),
    .occupancy(occ_s[1])
  );

  pipe_stage_latch #(.DATA_W(64), .BUBBLE_VAL(64'h13), .SKID(1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush_w),
    .in_valid(in_valid_w), .in_ready(in_ready_w), .in_data(in_data_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w),
    .occupancy(occ_w)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    flush_s[d]     = 1'b0;
    in_valid_s[d]  = 1'b0;
    in_data_s[d]   = 32'h0;
    out_ready_s[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(0);
    idle(1);
    flush_w = 1'b0; in_valid_w = 1'b0; in_data_w = 64'h0; out_ready_w = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (out_valid_s[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d: got %b want 0", d, out_valid_s[d]); end
      checks++; if (out_data_s[d] !== 32'h0) begin errors++; $display("FAIL reset_out_data dut%0d: got %h want 0", d, out_data_s[d]); end
      checks++; if (in_ready_s[d] !== 1'b0) begin errors++; $display("FAIL reset_in_ready dut%0d: got %b want 0", d, in_ready_s[d]); end
      checks++; if (occ_s[d] !== 2'd0) begin errors++; $display("FAIL reset_occ dut%0d: got %0d want 0", d, occ_s[d]); end
    end
    checks++; if (out_data_w !== 64'h13) begin errors++; $display("FAIL reset_bubble64: got %h want 13", out_data_w); end
    checks++; if (out_valid_w !== 1'b0) begin errors++; $display("FAIL reset_out_valid64: got %b want 0", out_valid_w); end
    cyc();
  endtask

  task automatic test_stream();
    logic [31:0] items [3];
    items[0] = 32'h11; items[1] = 32'h22; items[2] = 32'h33;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid_s[d]  = (c < 3);
        in_data_s[d]   = (c < 3) ? items[c] : 32'h0;
        out_ready_s[d] = 1'b1;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (c == 0) begin
          checks++; if (in_ready_s[d] !== 1'b1) begin errors++; $display("FAIL stream_first_ready dut%0d: got %b want 1", d, in_ready_s[d]); end
        end
        if (c >= 1 && c <= 3) begin
          checks++; if (out_valid_s[d] !== 1'b1 || out_data_s[d] !== items[c-1]) begin
            errors++; $display("FAIL stream_out dut%0d cyc%0d: got v=%b %h want v=1 %h", d, c, out_valid_s[d], out_data_s[d], items[c-1]);
          end
          $display("tb: stream dut%0d out %h", d, out_data_s[d]);
        end
        if (c == 4) begin
          checks++; if (out_valid_s[d] !== 1'b0 || out_data_s[d] !== 32'h0) begin
            errors++; $display("FAIL stream_drain dut%0d: got v=%b %h want v=0 0", d, out_valid_s[d], out_data_s[d]);
          end
        end
      end
      cyc();
    end
    idle(0);
    idle(1);
  endtask

  task automatic test_backpressure(input int d);
    logic [31:0] items [4];
    logic [31:0] prev_data;
    logic        prev_stall;
    int          in_idx;
    int          out_idx;
    items[0] = 32'hA0; items[1] = 32'hA1; items[2] = 32'hA2; items[3] = 32'hA3;
    in_idx = 0; out_idx = 0; prev_stall = 1'b0; prev_data = 32'h0;
    for (int c = 0; c < 30 && out_idx < 4; c++) begin
      in_valid_s[d]  = (in_idx < 4);
      in_data_s[d]   = (in_idx < 4) ? items[in_idx] : 32'h0;
      out_ready_s[d] = (c >= 4);
      @(negedge clk);
      checks++; if (occ_s[d] > ((d == 0) ? 2'd1 : 2'd2)) begin errors++; $display("FAIL bp_occ_bound dut%0d: got %0d", d, occ_s[d]); end
      if (d == 0) begin
        checks++; if (in_ready_s[d] !== (!out_valid_s[d] || out_ready_s[d])) begin
          errors++; $display("FAIL bp_ready_track dut0 cyc%0d: got %b want %b", c, in_ready_s[d], !out_valid_s[d] || out_ready_s[d]);
        end
      end
      if (c == 2) begin
        checks++; if (occ_s[d] !== ((d == 0) ? 2'd1 : 2'd2)) begin errors++; $display("FAIL bp_full_occ dut%0d: got %0d want %0d", d, occ_s[d], (d == 0) ? 1 : 2); end
        checks++; if (in_ready_s[d] !== 1'b0) begin errors++; $display("FAIL bp_full_ready dut%0d: got %b want 0", d, in_ready_s[d]); end
        checks++; if (out_data_s[d] !== 32'hA0) begin errors++; $display("FAIL bp_hold_data dut%0d: got %h want a0", d, out_data_s[d]); end
      end
      if (c == 4) begin
        checks++; if (in_ready_s[d] !== ((d == 0) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL bp_release_ready dut%0d: got %b want %b", d, in_ready_s[d], (d == 0) ? 1'b1 : 1'b0);
        end
      end
      if (prev_stall) begin
        checks++; if (out_valid_s[d] !== 1'b1 || out_data_s[d] !== prev_data) begin
          errors++; $display("FAIL bp_stall_stable dut%0d: got v=%b %h want v=1 %h", d, out_valid_s[d], out_data_s[d], prev_data);
        end
      end
      prev_stall = out_valid_s[d] && !out_ready_s[d];
      prev_data  = out_data_s[d];
      if (out_valid_s[d] && out_ready_s[d]) begin
        checks++; if (out_data_s[d] !== items[out_idx]) begin
          errors++; $display("FAIL bp_order dut%0d idx%0d: got %h want %h", d, out_idx, out_data_s[d], items[out_idx]);
        end
        $display("tb: backpressure dut%0d out %h", d, out_data_s[d]);
        out_idx++;
      end
      if (in_valid_s[d] && in_ready_s[d]) in_idx++;
      cyc();
    end
    checks++; if (out_idx != 4) begin errors++; $display("FAIL bp_timeout dut%0d: got %0d outputs want 4", d, out_idx); end
    idle(d);
  endtask

  task automatic test_flush();
    // Flush while holding two entries, with an offered (not accepted) input.
    in_valid_s[1] = 1'b1; in_data_s[1] = 32'hB0; out_ready_s[1] = 1'b0;
    cyc();
    in_data_s[1] = 32'hB1;
    cyc();
    flush_s[1] = 1'b1; in_data_s[1] = 32'hB2;
    @(negedge clk);
    checks++; if (occ_s[1] !== 2'd2 || in_ready_s[1] !== 1'b0) begin
      errors++; $display("FAIL flush_two_pre: got occ=%0d rdy=%b want occ=2 rdy=0", occ_s[1], in_ready_s[1]);
    end
    cyc();
    flush_s[1] = 1'b0; in_valid_s[1] = 1'b0; out_ready_s[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (out_valid_s[1] !== 1'b0 || out_data_s[1] !== 32'h0 || occ_s[1] !== 2'd0) begin
        errors++; $display("FAIL flush_two_post k%0d: got v=%b %h occ=%0d want v=0 0 occ=0", k, out_valid_s[1], out_data_s[1], occ_s[1]);
      end
      cyc();
    end
    // Flush in ONE with an input handshake that completes but is discarded.
    in_valid_s[1] = 1'b1; in_data_s[1] = 32'hB3; out_ready_s[1] = 1'b0;
    cyc();
    flush_s[1] = 1'b1; in_data_s[1] = 32'hB4;
    @(negedge clk);
    checks++; if (in_ready_s[1] !== 1'b1) begin errors++; $display("FAIL flush_one_ready: got %b want 1", in_ready_s[1]); end
    cyc();
    flush_s[1] = 1'b0; in_valid_s[1] = 1'b0; out_ready_s[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (out_valid_s[1] !== 1'b0 || occ_s[1] !== 2'd0) begin
        errors++; $display("FAIL flush_one_post k%0d: got v=%b occ=%0d want v=0 occ=0", k, out_valid_s[1], occ_s[1]);
      end
      cyc();
    end
    idle(1);
    // Flush held N cycles on SKID=0 while streaming gives N bubble cycles.
    for (int k = 0; k < 3; k++) begin
      flush_s[0] = 1'b1; in_valid_s[0] = 1'b1; in_data_s[0] = 32'hD0 + k; out_ready_s[0] = 1'b1;
      cyc();
      @(negedge clk);
      checks++; if (out_valid_s[0] !== 1'b0 || out_data_s[0] !== 32'h0) begin
        errors++; $display("FAIL flush_held k%0d: got v=%b %h want v=0 0", k, out_valid_s[0], out_data_s[0]);
      end
      #1;
    end
    idle(0);
    cyc();
  endtask

  task automatic test_flush_consume(input int d);
    in_valid_s[d] = 1'b1; in_data_s[d] = 32'hC0; out_ready_s[d] = 1'b0;
    cyc();
    in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b1; flush_s[d] = 1'b1;
    @(negedge clk);
    checks++; if (out_valid_s[d] !== 1'b1 || out_data_s[d] !== 32'hC0) begin
      errors++; $display("FAIL flush_consume_pre dut%0d: got v=%b %h want v=1 c0", d, out_valid_s[d], out_data_s[d]);
    end
    $display("tb: flush_consume dut%0d out %h", d, out_data_s[d]);
    cyc();
    flush_s[d] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (out_valid_s[d] !== 1'b0 || out_data_s[d] !== 32'h0 || occ_s[d] !== 2'd0) begin
        errors++; $display("FAIL flush_consume_post dut%0d k%0d: got v=%b %h occ=%0d want v=0 0 occ=0", d, k, out_valid_s[d], out_data_s[d], occ_s[d]);
      end
      cyc();
    end
    idle(d);
  endtask

  task automatic test_reset_mid();
    in_valid_s[1] = 1'b1; in_data_s[1] = 32'hE0; out_ready_s[1] = 1'b0;
    cyc();
    in_data_s[1] = 32'hE1;
    cyc();
    rst_n = 1'b0; in_data_s[1] = 32'hE2;
    @(negedge clk);
    checks++; if (in_ready_s[1] !== 1'b0) begin errors++; $display("FAIL midreset_ready_low: got %b want 0", in_ready_s[1]); end
    cyc();
    rst_n = 1'b1; in_valid_s[1] = 1'b0; out_ready_s[1] = 1'b1;
    @(negedge clk);
    checks++; if (out_valid_s[1] !== 1'b0 || out_data_s[1] !== 32'h0 || occ_s[1] !== 2'd0 || in_ready_s[1] !== 1'b1) begin
      errors++; $display("FAIL midreset_post: got v=%b %h occ=%0d rdy=%b want v=0 0 occ=0 rdy=1", out_valid_s[1], out_data_s[1], occ_s[1], in_ready_s[1]);
    end
    cyc();
    @(negedge clk);
    checks++; if (out_valid_s[1] !== 1'b0) begin errors++; $display("FAIL midreset_no_leak: got v=%b want 0", out_valid_s[1]); end
    cyc();
    idle(1);
  endtask

  task automatic test_random();
    logic [63:0] q [$];
    logic [63:0] prev_data;
    logic        prev_stall;
    logic        m_out_fire;
    logic        m_in_fire;
    prev_stall = 1'b0; prev_data = 64'h0;
    for (int c = 0; c < 10000; c++) begin
      in_valid_w  = ($urandom_range(0, 99) < 60);
      out_ready_w = ($urandom_range(0, 99) < 55);
      flush_w     = ($urandom_range(0, 99) < 3);
      in_data_w   = {$urandom, $urandom};
      @(negedge clk);
      checks++; if (occ_w !== 2'(q.size())) begin errors++; $display("FAIL rnd_occ cyc%0d: got %0d want %0d", c, occ_w, q.size()); end
      checks++; if (in_ready_w !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready cyc%0d: got %b want %b", c, in_ready_w, q.size() < 2); end
      checks++; if (out_valid_w !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc%0d: got %b want %b", c, out_valid_w, q.size() != 0); end
      checks++;
      if (q.size() == 0) begin
        if (out_data_w !== 64'h13) begin errors++; $display("FAIL rnd_bubble cyc%0d: got %h want 13", c, out_data_w); end
      end else begin
        if (out_data_w !== q[0]) begin errors++; $display("FAIL rnd_data cyc%0d: got %h want %h", c, out_data_w, q[0]); end
      end
      if (prev_stall) begin
        checks++; if (out_data_w !== prev_data) begin errors++; $display("FAIL rnd_stall_stable cyc%0d: got %h want %h", c, out_data_w, prev_data); end
      end
      m_out_fire = (q.size() != 0) && out_ready_w;
      m_in_fire  = in_valid_w && (q.size() < 2);
      prev_stall = (q.size() != 0) && !out_ready_w && !flush_w;
      prev_data  = out_data_w;
      if (m_out_fire) void'(q.pop_front());
      if (flush_w) q.delete();
      else if (m_in_fire) q.push_back(in_data_w);
      cyc();
      if (errors > 20) break;
    end
    flush_w = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure(1);
    test_backpressure(0);
    test_flush();
    test_flush_consume(1);
    test_flush_consume(0);
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
